// File: rtl/fetch_pkg.sv
// Shared definitions for the RV64 instruction fetch stage: constants, FSM
// state encoding and the layout of the fetch-to-decode output register.
package fetch_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        misalign;
  } out_entry_t;

  function automatic logic is_misaligned(input logic [63:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // A misaligned target is delivered to decode as a NOP tagged with the fault.
  function automatic out_entry_t fault_entry(input logic [63:0] pc);
    out_entry_t e;
    e.valid    = 1'b1;
    e.pc       = pc;
    e.inst     = INST_NOP;
    e.misalign = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Handshake bundle of the fetch stage: instruction memory port, PC redirect
// and the valid/ready link to decode. "master" is the fetch side.
interface fetch_if;
  import fetch_pkg::*;

  logic        o_IMemReqValid_1;
  logic        i_IMemReqReady_1;
  logic [63:0] o_IMemAddr_64;
  logic        i_IMemRespValid_1;
  logic [31:0] i_IMemRespData_32;
  logic        i_Redirect_1;
  logic [63:0] i_RedirectPC_64;
  logic        o_IFValid_1;
  logic        i_IDReady_1;
  logic [63:0] o_PC_64;
  logic [31:0] o_Inst_32;
  logic        o_Misalign_1;

  modport master (
    output o_IMemReqValid_1, o_IMemAddr_64, o_IFValid_1, o_PC_64, o_Inst_32, o_Misalign_1,
    input  i_IMemReqReady_1, i_IMemRespValid_1, i_IMemRespData_32,
    input  i_Redirect_1, i_RedirectPC_64, i_IDReady_1
  );

  modport slave (
    input  o_IMemReqValid_1, o_IMemAddr_64, o_IFValid_1, o_PC_64, o_Inst_32, o_Misalign_1,
    output i_IMemReqReady_1, i_IMemRespValid_1, i_IMemRespData_32,
    output i_Redirect_1, i_RedirectPC_64, i_IDReady_1
  );

endinterface

// File: rtl/fetch.sv
// RV64 instruction fetch: holds the PC, keeps at most one instruction read in
// flight and presents {PC, instruction} to decode through a valid/ready register.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic     i_Clk,
  input  logic     i_Rst,
  fetch_if.master  fif
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  out_entry_t   out_q, out_d;
  // Set while a stale response is being drained after a misaligned redirect.
  logic         fault_pend_q, fault_pend_d;

  logic out_free;
  logic out_xfer;
  logic req_valid;
  logic resp_valid;
  logic redirect;
  logic stale_outstanding;

  assign redirect   = fif.i_Redirect_1;
  assign resp_valid = fif.i_IMemRespValid_1;
  assign out_xfer   = out_q.valid & fif.i_IDReady_1;
  assign out_free   = ~out_q.valid | fif.i_IDReady_1;
  assign req_valid  = (state_q == S_REQ) & out_free & ~redirect;

  // A response is still owed after this cycle only if we were waiting and it
  // has not arrived yet.
  assign stale_outstanding = ((state_q == S_WAIT) | (state_q == S_DROP)) & ~resp_valid;

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    out_d        = out_q;
    fault_pend_d = fault_pend_q;

    if (out_xfer) begin
      out_d.valid = 1'b0;
    end

    if (redirect) begin
      pc_d         = fif.i_RedirectPC_64;
      out_d        = '0;
      fault_pend_d = 1'b0;
      if (stale_outstanding) begin
        state_d      = S_DROP;
        fault_pend_d = is_misaligned(fif.i_RedirectPC_64);
      end else if (is_misaligned(fif.i_RedirectPC_64)) begin
        out_d   = fault_entry(fif.i_RedirectPC_64);
        state_d = S_FAULT;
      end else begin
        state_d = S_REQ;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_valid & fif.i_IMemReqReady_1) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (resp_valid) begin
            out_d.valid    = 1'b1;
            out_d.pc       = pc_q;
            out_d.inst     = fif.i_IMemRespData_32;
            out_d.misalign = 1'b0;
            pc_d           = pc_q + 64'd4;
            state_d        = S_REQ;
          end
        end
        S_DROP: begin
          if (resp_valid) begin
            fault_pend_d = 1'b0;
            if (fault_pend_q) begin
              out_d   = fault_entry(pc_q);
              state_d = S_FAULT;
            end else begin
              state_d = S_REQ;
            end
          end
        end
        S_FAULT: begin
          // Parked until the next redirect; responses here are protocol errors.
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      out_q        <= '0;
      fault_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      out_q        <= out_d;
      fault_pend_q <= fault_pend_d;
    end
  end

  assign fif.o_IMemReqValid_1 = req_valid;
  assign fif.o_IMemAddr_64    = pc_q;
  assign fif.o_IFValid_1      = out_q.valid;
  assign fif.o_PC_64          = out_q.pc;
  assign fif.o_Inst_32        = out_q.inst;
  assign fif.o_Misalign_1     = out_q.misalign;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed cycle tables, hand-written corner
// sequences, a PC-wrap instance and a randomized run against a delivery model.
module tb_fetch;
  import fetch_pkg::*;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        idr;
    logic        redir;
    logic [63:0] rpc;
    logic        req;
    logic [63:0] addr;
    logic        ifv;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mis;
  } vec_t;

  localparam logic [31:0] D1 = 32'h0010_0093;
  localparam logic [31:0] D2 = 32'h0000_0533;
  localparam logic [31:0] D3 = 32'h00A0_0513;
  localparam logic [31:0] D4 = 32'h0015_0513;
  localparam logic [31:0] DX = 32'hDEAD_BEEF;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  fetch_if mif ();
  fetch_if wif ();

  fetch u_dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .fif   (mif.master)
  );

  fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .i_Clk (clk),
    .i_Rst (rst),
    .fif   (wif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rdata,
                              input logic idr, input logic redir, input logic [63:0] rpc,
                              input logic req, input logic [63:0] addr, input logic ifv,
                              input logic [63:0] pc, input logic [31:0] inst, input logic mis);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.idr = idr; v.redir = redir; v.rpc = rpc;
    v.req = req; v.addr = addr; v.ifv = ifv; v.pc = pc; v.inst = inst; v.mis = mis;
    return v;
  endfunction

  // Instruction memory contents used by the randomized run.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[33:2] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input bit ok, input string name, input logic [162:0] act,
                       input logic [162:0] exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_m(input vec_t v);
    mif.i_IMemReqReady_1  = v.rdy;
    mif.i_IMemRespValid_1 = v.rv;
    mif.i_IMemRespData_32 = v.rdata;
    mif.i_IDReady_1       = v.idr;
    mif.i_Redirect_1      = v.redir;
    mif.i_RedirectPC_64   = v.rpc;
  endtask

  task automatic idle_w();
    wif.i_IMemReqReady_1  = 1'b0;
    wif.i_IMemRespValid_1 = 1'b0;
    wif.i_IMemRespData_32 = '0;
    wif.i_IDReady_1       = 1'b0;
    wif.i_Redirect_1      = 1'b0;
    wif.i_RedirectPC_64   = '0;
  endtask

  // Called at posedge+1; drives one cycle, compares at the negedge, returns at posedge+1.
  task automatic apply(input vec_t v, input string name);
    logic [162:0] act, exp;
    drive_m(v);
    @(negedge clk);
    act = {mif.o_IMemReqValid_1, mif.o_IMemAddr_64, mif.o_IFValid_1,
           v.ifv ? {mif.o_PC_64, mif.o_Inst_32, mif.o_Misalign_1} : 97'd0};
    exp = {v.req, v.addr, v.ifv, v.ifv ? {v.pc, v.inst, v.mis} : 97'd0};
    check(act == exp, name, act, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_m(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle_w();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    logic [162:0] act;
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    do_reset();

    act = {66'd0, mif.o_IFValid_1, mif.o_PC_64, mif.o_Inst_32, mif.o_Misalign_1};
    check(act == '0, "reset_out", act, '0);

    // Reset fetch, decode stall, redirects in S_WAIT / with response, misaligned target.
    tbl.push_back(mk(1, 0, 0,  0, 0, 0, 1, 64'h8000_0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, D1, 0, 0, 0, 0, 64'h8000_0000, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 64'h8000_0004, 1, 64'h8000_0000, D1, 0));
    tbl.push_back(mk(1, 0, 0,  1, 0, 0, 1, 64'h8000_0004, 1, 64'h8000_0000, D1, 0));
    tbl.push_back(mk(1, 0, 0,  0, 1, 64'h8000_0100, 0, 64'h8000_0004, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0, 0, 0, 64'h8000_0100, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0, 0, 0, 64'h8000_0100, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, DX, 0, 0, 0, 0, 64'h8000_0100, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0, 0, 1, 64'h8000_0100, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, D2, 0, 1, 64'h8000_0180, 0, 64'h8000_0100, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  0, 0, 0, 1, 64'h8000_0180, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0, 0, 1, 64'h8000_0180, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, D3, 0, 0, 0, 0, 64'h8000_0180, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,  1, 0, 0, 1, 64'h8000_0184, 1, 64'h8000_0180, D3, 0));
    tbl.push_back(mk(1, 0, 0,  0, 1, 64'h8000_0102, 0, 64'h8000_0184, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0, 0, 0, 64'h8000_0102, 1, 64'h8000_0102, INST_NOP, 1));
    tbl.push_back(mk(1, 0, 0,  1, 0, 0, 0, 64'h8000_0102, 1, 64'h8000_0102, INST_NOP, 1));
    tbl.push_back(mk(1, 0, 0,  1, 0, 0, 0, 64'h8000_0102, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  1, 1, 64'h8000_0200, 0, 64'h8000_0102, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  1, 0, 0, 1, 64'h8000_0200, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, D4, 0, 0, 0, 0, 64'h8000_0200, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0, 0, 0, 64'h8000_0204, 1, 64'h8000_0200, D4, 0));
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Misaligned redirect while a response is outstanding: fault appears after the drain.
    apply(mk(1, 0, 0,  1, 0, 0, 1, 64'h8000_0204, 1, 64'h8000_0200, D4, 0), "mis_wait_req");
    apply(mk(1, 0, 0,  1, 1, 64'h8000_0301, 0, 64'h8000_0204, 0, 0, 0, 0), "mis_wait_redir");
    apply(mk(1, 0, 0,  1, 0, 0, 0, 64'h8000_0301, 0, 0, 0, 0), "mis_wait_drop");
    apply(mk(1, 1, DX, 0, 0, 0, 0, 64'h8000_0301, 0, 0, 0, 0), "mis_wait_drain");
    apply(mk(1, 0, 0,  0, 0, 0, 0, 64'h8000_0301, 1, 64'h8000_0301, INST_NOP, 1), "mis_wait_fault");
    apply(mk(1, 0, 0,  0, 1, 64'h8000_0400, 0, 64'h8000_0301, 1, 64'h8000_0301, INST_NOP, 1),
          "fault_exit");
    apply(mk(1, 0, 0,  1, 0, 0, 1, 64'h8000_0400, 0, 0, 0, 0), "pre_reset_req");

    // Reset mid-operation: the late response must be ignored in S_REQ.
    rst = 1'b1;
    drive_m(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(mk(0, 1, 32'h1234_5678, 0, 0, 0, 1, 64'h8000_0000, 0, 0, 0, 0), "rst_late_resp");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 64'h8000_0000, 0, 0, 0, 0), "rst_resp_ignored");

    // PC wrap on the second instance.
    do_reset();
    wif.i_IMemReqReady_1 = 1'b1;
    wif.i_IDReady_1      = 1'b1;
    @(negedge clk);
    act = {wif.o_IMemReqValid_1, wif.o_IMemAddr_64, 98'd0};
    check(act == {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 98'd0}, "wrap_req0", act,
          {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 98'd0});
    @(posedge clk);
    #1;
    wif.i_IMemRespValid_1 = 1'b1;
    wif.i_IMemRespData_32 = D1;
    @(posedge clk);
    #1;
    wif.i_IMemRespValid_1 = 1'b0;
    @(negedge clk);
    act = {wif.o_IMemReqValid_1, wif.o_IMemAddr_64, wif.o_IFValid_1, wif.o_PC_64,
           wif.o_Inst_32, wif.o_Misalign_1};
    check(act == {1'b1, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, D1, 1'b0}, "wrap_req1", act,
          {1'b1, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, D1, 1'b0});
    @(posedge clk);
    #1;
    idle_w();

    // Randomized run: the model tracks which instruction decode must receive next.
    do_reset();
    begin
      bit          pend, exp_fault, dead, prev_hold;
      int          cnt, delivered;
      logic [63:0] pend_addr, exp_pc, rpc;
      logic [96:0] prev_out, cur_out;
      vec_t        v;
      pend = 0; exp_fault = 0; dead = 0; prev_hold = 0; cnt = 0; delivered = 0;
      pend_addr = '0; prev_out = '0;
      exp_pc = 64'h8000_0000;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        v = mk(0, 0, $urandom, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (pend) begin
          if (cnt == 1) begin
            v.rv = 1'b1;
            v.rdata = mem_word(pend_addr);
            pend = 0;
          end else begin
            cnt--;
          end
        end else if ($urandom_range(0, 49) == 0) begin
          v.rv = 1'b1;
        end
        v.rdy   = ($urandom_range(0, 3) != 0);
        v.idr   = ($urandom_range(0, 9) < 7);
        v.redir = ($urandom_range(0, 39) == 0);
        rpc = 64'h8000_0000 + (64'($urandom_range(0, 1023)) << 2);
        if ($urandom_range(0, 4) == 0) rpc = rpc + 64'($urandom_range(1, 3));
        v.rpc = rpc;
        drive_m(v);
        @(negedge clk);
        cur_out = {mif.o_PC_64, mif.o_Inst_32, mif.o_Misalign_1};
        if (prev_hold)
          check(mif.o_IFValid_1 && cur_out == prev_out, "rand_stall_stable",
                {mif.o_IFValid_1, cur_out}, {1'b1, prev_out});
        if (v.redir)
          check(!mif.o_IMemReqValid_1, "rand_redirect_gate", mif.o_IMemReqValid_1, 0);
        if (mif.o_IFValid_1 && v.idr) begin
          if (dead) begin
            check(0, "rand_after_fault", cur_out, 0);
          end else if (exp_fault) begin
            check(cur_out == {exp_pc, INST_NOP, 1'b1}, "rand_fault", cur_out,
                  {exp_pc, INST_NOP, 1'b1});
            dead = 1;
          end else begin
            check(cur_out == {exp_pc, mem_word(exp_pc), 1'b0}, "rand_deliver", cur_out,
                  {exp_pc, mem_word(exp_pc), 1'b0});
            exp_pc = exp_pc + 64'd4;
            delivered++;
          end
        end
        if (mif.o_IMemReqValid_1)
          check(!(dead || exp_fault), "rand_req_in_fault", {dead, exp_fault}, 0);
        if (mif.o_IMemReqValid_1 && v.rdy) begin
          check(!pend, "rand_one_outstanding", pend, 0);
          pend      = 1;
          cnt       = $urandom_range(1, 4);
          pend_addr = mif.o_IMemAddr_64;
        end
        if (v.redir) begin
          exp_pc    = v.rpc;
          exp_fault = is_misaligned(v.rpc);
          dead      = 0;
        end
        prev_hold = mif.o_IFValid_1 && !v.idr && !v.redir;
        prev_out  = cur_out;
        @(posedge clk);
        #1;
      end
      check(delivered > 100, "rand_progress", delivered, 101);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
